pipelined_addsub: RTL and testbench
===================================

Name: pipelined_addsub

Overview:
- Parametrised successor to the team's 4-bit ripple adder.
- Computes WIDTH-bit add or subtract with carry-in over a STAGES-deep pipeline. Each stage resolves one WIDTH/STAGES-bit slice and registers the carry into the next stage.
- Valid/ready handshake on input and output; throughput of one operation per cycle.
- Used as the standard arithmetic datapath block wherever the ripple path through a full WIDTH-bit adder is too long for one cycle.

Parameters:
- WIDTH, 16, operand/result width in bits; must be ≥ 2.
- STAGES, 4, pipeline depth and slice count; WIDTH % STAGES must be 0, otherwise elaboration fails. STAGES = 1 is legal and gives a single registered stage.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand valid
- in_ready  output  1  block can accept an operand this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in; ignored when sub = 1
- sub  input  1  0: a + b + cin; 1: a − b (computed as a + ~b + 1)
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts the result
- sum  output  WIDTH  result
- cout  output  1  carry out of the MSB; in subtract mode, 1 means no borrow
- ovf  output  1  signed overflow, defined as carry into MSB XOR carry out of MSB

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, rst.
- Reset: on a clk edge with rst = 1, all stage valid bits, sum, cout and ovf clear to 0. in_ready is 1 in the cycle after reset. rst asserted mid-stream flushes all in-flight operations; no result is emitted for them.
- Accept: an operation is accepted on an edge where in_valid && in_ready. Operands are sampled only on that edge.
- Stall rule: advance = !out_valid || out_ready, and in_ready = advance. The whole pipeline stalls together.
  - While stalled, every stage register holds its value.
  - sum, cout, ovf and out_valid must stay stable until out_ready is seen.
- Latency: with no stall, out_valid rises STAGES cycles after the accept edge.
- Ordering: results leave in acceptance order, with no loss and no duplication.
- Bubbles: an edge with advance = 1 but no accept inserts a bubble (stage valid = 0).
- Slice datapath: stage k (k = 0..STAGES−1) adds slice k of a and b_eff plus the carry registered from stage k−1; stage 0 uses c0.
  - b_eff = sub ? ~b : b.
  - c0 = sub ? 1 : cin.
  - Unprocessed upper operand slices travel through per-stage skew registers.
  - Finished lower sum slices travel forward in per-stage result registers.
- Output stage: the last stage also computes cout and ovf; ovf uses the carry into bit WIDTH−1.
- Arithmetic: all wrap modulo 2^WIDTH unless the optional feature is enabled.
- Boundary cases:
  - All-ones plus 1 gives sum = 0, cout = 1.
  - A carry generated in slice 0 must propagate through every later slice in the same operation.
  - When sub = 1, cin has no effect.
  - out_ready high with out_valid low is harmless.
  - in_valid is permitted to drop while in_ready is low.

Optional Feature:
- Macro: ADDER_SAT_EN.
- Defined: when ovf = 1, sum is clamped.
  - Clamps to 2^(WIDTH−1)−1 if a[WIDTH−1] = 0, otherwise to −2^(WIDTH−1).
  - cout and ovf are still reported unchanged.
  - Clamping is applied in the last stage; latency is unchanged.
- Undefined: sum wraps; no clamp logic is present.

Test Plan (WIDTH = 16, STAGES = 4):
- 0x00FF + 0x0001, cin = 0 → 4 cycles later sum = 0x0100, cout = 0, ovf = 0. Covers the carry crossing a slice boundary.
- 0xFFFF + 0x0001 → sum = 0x0000, cout = 1, ovf = 0.
- 0x7FFF + 0x0001 → sum = 0x8000, ovf = 1. With ADDER_SAT_EN: sum = 0x7FFF.
- Subtract mode, with cin = 1 to confirm it is ignored:
  - 0x0005 − 0x0007 → sum = 0xFFFE, cout = 0.
  - 0x8000 − 0x0001 → sum = 0x7FFF, ovf = 1. With ADDER_SAT_EN: sum = 0x8000.
- 8 back-to-back operations with out_ready = 1 → 8 results on 8 consecutive cycles, in order, first result 4 cycles after the first accept.
- Pipeline full, out_ready = 0 for 3 cycles → in_ready = 0 and outputs held stable; then out_ready = 1 → all results emitted in order with no loss or duplication.
- rst pulsed for one cycle with 3 operations in flight → next cycle out_valid = 0, sum = 0, in_ready = 1; no stale results appear afterwards.

Source files
------------

// File: rtl/pipelined_addsub.sv
// WIDTH-bit add/subtract with carry-in, resolved one WIDTH/STAGES-bit slice per pipeline stage.
// Define ADDER_SAT_EN to clamp the sum to the signed range whenever ovf is set.
module pipelined_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SW = WIDTH / STAGES;

    generate
        if (WIDTH < 2 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
            $error("pipelined_addsub: WIDTH must be >= 2 and a multiple of STAGES");
        end
    endgenerate

    // One rank of pipeline state: skewed operands, incoming carry, finished low slices.
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             carry;
        logic [WIDTH-1:0] res;
    } rank_t;

    logic [STAGES-1:0] valid_q;
    rank_t             rank_q [STAGES];
    rank_t             nxt_w  [STAGES];
    rank_t             in_rank_w;
    logic [SW:0]       slice_w [STAGES];

    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             ovf_d;
    logic             msb_carry_w;
    logic             advance;

    // The whole pipeline moves only when the output slot is empty or being drained.
    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance;

    assign in_rank_w.a     = a;
    assign in_rank_w.b     = sub ? ~b : b;
    assign in_rank_w.carry = sub ? 1'b1 : cin;
    assign in_rank_w.res   = '0;

    // NOTE: every always_comb output is given a full default before any partial update,
    // so no path leaves a bit unassigned and no latch is inferred.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            nxt_w[k]   = rank_q[k];
            slice_w[k] = {1'b0, rank_q[k].a[k*SW +: SW]}
                       + {1'b0, rank_q[k].b[k*SW +: SW]}
                       + {{SW{1'b0}}, rank_q[k].carry};
            nxt_w[k].res[k*SW +: SW] = slice_w[k][SW-1:0];
            nxt_w[k].carry           = slice_w[k][SW];
        end
    end

    // Carry into the MSB recovered from the MSB's own sum and operand bits.
    always_comb begin
        msb_carry_w = nxt_w[STAGES-1].res[WIDTH-1]
                    ^ nxt_w[STAGES-1].a[WIDTH-1]
                    ^ nxt_w[STAGES-1].b[WIDTH-1];
        cout_d      = nxt_w[STAGES-1].carry;
        ovf_d       = cout_d ^ msb_carry_w;
        sum_d       = nxt_w[STAGES-1].res;
`ifdef ADDER_SAT_EN
        if (ovf_d) begin
            sum_d = nxt_w[STAGES-1].a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                               : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (advance) begin
            valid_q[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                valid_q[k] <= valid_q[k-1];
            end
            out_valid_q <= valid_q[STAGES-1];
            if (valid_q[STAGES-1]) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    // NOTE: the operand/result ranks carry no reset; the valid bits alone decide
    // whether their contents mean anything.
    always_ff @(posedge clk) begin
        if (advance) begin
            rank_q[0] <= in_rank_w;
            for (int k = 1; k < STAGES; k++) begin
                rank_q[k] <= nxt_w[k-1];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub: directed vectors, handshake corner cases
// and randomized traffic against an arithmetic reference model with a result queue.
module tb_pipelined_addsub;

    localparam int WIDTH  = 16;
    localparam int STAGES = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    always #5 clk = ~clk;

    pipelined_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } res_t;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic             sub;
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    res_t exp_q[$];
    int   out_log[$];

    // Reference: plain integer arithmetic plus the signed-overflow rule on operand signs.
    function automatic res_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic ci, input logic s);
        res_t           r;
        logic [WIDTH:0] full;
        if (s) full = {1'b0, x} + {1'b0, ~y} + (WIDTH+1)'(1);
        else   full = {1'b0, x} + {1'b0, y} + (WIDTH+1)'(ci);
        r.sum  = full[WIDTH-1:0];
        r.cout = full[WIDTH];
        if (s) r.ovf = (x[WIDTH-1] != y[WIDTH-1]) && (r.sum[WIDTH-1] != x[WIDTH-1]);
        else   r.ovf = (x[WIDTH-1] == y[WIDTH-1]) && (r.sum[WIDTH-1] != x[WIDTH-1]);
`ifdef ADDER_SAT_EN
        if (r.ovf) r.sum = x[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: sample handshakes mid-cycle, update the scoreboard, step past the edge.
    task automatic tick();
        logic fire_in, fire_out, hold, r;
        res_t got, e;
        #1;
        r        = rst;
        fire_in  = in_valid && in_ready && !r;
        fire_out = out_valid && out_ready && !r;
        hold     = out_valid && !out_ready && !r;
        got.sum  = sum;
        got.cout = cout;
        got.ovf  = ovf;
        if (hold) check("stall_in_ready", 32'(in_ready), 32'(0));
        if (fire_out) begin
            out_log.push_back(cyc);
            check("out_expected", 32'(exp_q.size() != 0), 32'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_sum", 32'(got.sum), 32'(e.sum));
                check("sb_cout", 32'(got.cout), 32'(e.cout));
                check("sb_ovf", 32'(got.ovf), 32'(e.ovf));
            end
        end
        if (fire_in) exp_q.push_back(model(a, b, cin, sub));
        @(posedge clk);
        cyc++;
        #1;
        if (r) exp_q.delete();
        if (hold) begin
            check("hold_valid", 32'(out_valid), 32'(1));
            check("hold_sum", 32'(sum), 32'(got.sum));
            check("hold_cout", 32'(cout), 32'(got.cout));
            check("hold_ovf", 32'(ovf), 32'(got.ovf));
        end
    endtask

    task automatic rand_op();
        a   = WIDTH'($urandom);
        b   = WIDTH'($urandom);
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t           vecs[8];
        int             lat;
        int             n;
        int             first_acc;
        int             pending;
        logic [WIDTH-1:0] held_sum;

        vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
`ifdef ADDER_SAT_EN
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1};
`else
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
`endif
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[5] = '{16'h1234, 16'h0F0F, 1'b1, 1'b0, 16'h2144, 1'b0, 1'b0};
        vecs[6] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
        vecs[7] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_sum", 32'(sum), 32'(0));
        check("rst_cout", 32'(cout), 32'(0));
        check("rst_ovf", 32'(ovf), 32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(1));

        // Directed vectors, one at a time, with latency measured from the accept edge.
        for (int i = 0; i < 8; i++) begin
            a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin; sub = vecs[i].sub;
            in_valid = 1'b1; out_ready = 1'b1;
            tick();
            in_valid = 1'b0;
            lat = 0;
            while (!out_valid && lat < 12) begin
                tick();
                lat++;
            end
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(STAGES));
            check($sformatf("vec%0d_sum", i), 32'(sum), 32'(vecs[i].sum));
            check($sformatf("vec%0d_cout", i), 32'(cout), 32'(vecs[i].cout));
            check($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
            tick();
        end

        // Eight back-to-back operations must emerge on eight consecutive cycles.
        out_log.delete();
        out_ready = 1'b1;
        first_acc = cyc + 1;
        for (int i = 0; i < 8; i++) begin
            rand_op();
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        n = 0;
        while (out_log.size() < 8 && n < 40) begin
            tick();
            n++;
        end
        check("b2b_count", 32'(out_log.size()), 32'(8));
        if (out_log.size() == 8) begin
            check("b2b_first_latency", 32'(out_log[0] - first_acc), 32'(STAGES));
            for (int i = 1; i < 8; i++) begin
                check("b2b_consecutive", 32'(out_log[i] - out_log[i-1]), 32'(1));
            end
        end

        // Fill the pipeline against a blocked output, hold three cycles, then drain.
        out_ready = 1'b0;
        n = 0;
        while (in_ready && n < 20) begin
            rand_op();
            in_valid = 1'b1;
            tick();
            n++;
        end
        check("full_in_ready", 32'(in_ready), 32'(0));
        in_valid = 1'b0;
        held_sum = sum;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("full_held_sum", 32'(sum), 32'(held_sum));
        end
        pending = exp_q.size();
        out_log.delete();
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() > 0 && n < 40) begin
            tick();
            n++;
        end
        for (int i = 0; i < 3; i++) tick();
        check("drain_empty", 32'(exp_q.size()), 32'(0));
        check("drain_count", 32'(out_log.size()), 32'(pending));

        // Reset with three operations in flight flushes them all.
        for (int i = 0; i < 3; i++) begin
            rand_op();
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("flush_out_valid", 32'(out_valid), 32'(0));
        check("flush_sum", 32'(sum), 32'(0));
        check("flush_in_ready", 32'(in_ready), 32'(1));
        out_log.delete();
        for (int i = 0; i < 10; i++) tick();
        check("flush_no_stale", 32'(out_log.size()), 32'(0));

        // Randomized traffic with random back-pressure.
        for (int i = 0; i < 400; i++) begin
            rand_op();
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() > 0 && n < 40) begin
            tick();
            n++;
        end
        check("random_drain_empty", 32'(exp_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
